wide_compare_seq: RTL and testbench

Multi-cycle magnitude comparator for operands wider than a single comparator slice. It latches two WORDS×W-bit operands on a start handshake and walks them one W-bit word per cycle, most-significant word first, through one internal nbit_comparator instance (n = W). It reports registered greater, equal and less flags plus the number of words examined. It serves as the sequencing controller that time-shares one comparator slice across wide operand compares.

---
 rtl/wide_compare_seq.sv | 184 ++++++++++++++++++
 tb/tb_wide_compare_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_compare_seq.sv
// Multi-cycle unsigned magnitude comparator: walks WORDS x W-bit operands MSW-first through one W-bit slice.
// Optional macro EARLY_EXIT_EN stops the scan at the first unequal word; otherwise the scan is constant-time.

module nbit_comparator #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         gt_in,
    input  logic         eq_in,
    input  logic         lt_in,
    output logic         gt_out,
    output logic         eq_out,
    output logic         lt_out
);

    logic same;

    // The cascade inputs only decide the result when this slice sees equal words.
    always_comb begin
        same   = (a == b);
        gt_out = (a > b) | (same & gt_in);
        eq_out = same & eq_in;
        lt_out = (a < b) | (same & lt_in);
    end

endmodule

module wide_compare_seq #(
    parameter int W = 16,
    parameter int WORDS = 4,
    localparam int CW = $clog2(WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [W*WORDS-1:0]   a_in,
    input  logic [W*WORDS-1:0]   b_in,
    output logic                 busy,
    output logic                 done,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt,
    output logic [CW-1:0]        words_used
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [W*WORDS-1:0]   a_q, a_d;
    logic [W*WORDS-1:0]   b_q, b_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dec_q, dec_d;
    logic                 dgt_q, dgt_d;
    logic                 dlt_q, dlt_d;
    logic                 busy_d, done_d, gt_d, eq_d, lt_d;
    logic [CW-1:0]        words_d;

    logic [W-1:0]         a_word, b_word;
    logic                 cmp_gt, cmp_eq, cmp_lt;
    logic                 accept, last_word, fin_gt, fin_lt;

    assign a_word = a_q[idx_q*W +: W];
    assign b_word = b_q[idx_q*W +: W];

    nbit_comparator #(.N(W)) u_slice (
        .a      (a_word),
        .b      (b_word),
        .gt_in  (1'b0),
        .eq_in  (1'b1),
        .lt_in  (1'b0),
        .gt_out (cmp_gt),
        .eq_out (cmp_eq),
        .lt_out (cmp_lt)
    );

    // The closing edge of DONE also accepts a new start, so compares run back to back every j+1 cycles.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        dgt_d   = dgt_q;
        dlt_d   = dlt_q;
        gt_d    = gt;
        eq_d    = eq;
        lt_d    = lt;
        words_d = words_used;

        accept  = start && ((state_q == IDLE) || (state_q == DONE));
        fin_gt  = dec_q ? dgt_q : cmp_gt;
        fin_lt  = dec_q ? dlt_q : cmp_lt;
`ifdef EARLY_EXIT_EN
        last_word = (idx_q == '0) || !cmp_eq;
`else
        last_word = (idx_q == '0);
`endif

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                if (!dec_q && !cmp_eq) begin
                    dec_d = 1'b1;
                    dgt_d = cmp_gt;
                    dlt_d = cmp_lt;
                end
                if (last_word) begin
                    state_d = DONE;
                    gt_d    = fin_gt;
                    lt_d    = fin_lt;
                    eq_d    = !fin_gt && !fin_lt;
                    words_d = cnt_q + 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = a_in;
            b_d     = b_in;
            idx_d   = IW'(WORDS - 1);
            cnt_d   = '0;
            dec_d   = 1'b0;
            dgt_d   = 1'b0;
            dlt_d   = 1'b0;
            gt_d    = 1'b0;
            eq_d    = 1'b0;
            lt_d    = 1'b0;
            words_d = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= IW'(WORDS - 1);
            cnt_q      <= '0;
            dec_q      <= 1'b0;
            dgt_q      <= 1'b0;
            dlt_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gt         <= 1'b0;
            eq         <= 1'b0;
            lt         <= 1'b0;
            words_used <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            dgt_q      <= dgt_d;
            dlt_q      <= dlt_d;
            busy       <= busy_d;
            done       <= done_d;
            gt         <= gt_d;
            eq         <= eq_d;
            lt         <= lt_d;
            words_used <= words_d;
        end
    end

endmodule

// File: tb/tb_wide_compare_seq.sv
// Scoreboard bench for wide_compare_seq: a 16x4 instance for directed/streaming/reset cases and an 8x2 instance for random pairs.
// Build with or without EARLY_EXIT_EN; expected latency and words_used follow the selected build.

module tb_wide_compare_seq;

    localparam int W = 16;
    localparam int WORDS = 4;
    localparam int CW = $clog2(WORDS + 1);
    localparam int W2 = 8;
    localparam int WORDS2 = 2;
    localparam int CW2 = $clog2(WORDS2 + 1);

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   words;
        int   due;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        gt;
        logic        eq;
        logic        lt;
        int          early_words;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [W*WORDS-1:0] a_in, b_in;
    logic busy, done, gt, eq, lt;
    logic [CW-1:0] words_used;

    logic start2;
    logic [W2*WORDS2-1:0] a2, b2;
    logic busy2, done2, gt2, eq2, lt2;
    logic [CW2-1:0] words_used2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t mon1_e, mon2_e;
    vec_t vecs[9];

    wide_compare_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt),
        .words_used (words_used)
    );

    wide_compare_seq #(.W(W2), .WORDS(WORDS2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .a_in       (a2),
        .b_in       (b2),
        .busy       (busy2),
        .done       (done2),
        .gt         (gt2),
        .eq         (eq2),
        .lt         (lt2),
        .words_used (words_used2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Arithmetic reference; in the early-exit build words = WORDS - (index of highest differing word).
    function automatic void refCompare(input logic [63:0] a, input logic [63:0] b, input int w, input int nw,
                                       output logic rgt, output logic req, output logic rlt, output int words);
        logic [63:0] mask;
        logic found;
        mask  = (64'h1 << w) - 64'h1;
        rgt   = (a > b);
        req   = (a == b);
        rlt   = (a < b);
        words = nw;
        found = 1'b0;
`ifdef EARLY_EXIT_EN
        for (int k = nw - 1; k >= 0; k--) begin
            if (!found && (((a >> (k*w)) & mask) != ((b >> (k*w)) & mask))) begin
                words = nw - k;
                found = 1'b1;
            end
        end
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending compare (cycle %0d)", cyc);
            end else begin
                mon1_e = q1.pop_front();
                checkOutput("gt", gt, mon1_e.gt);
                checkOutput("eq", eq, mon1_e.eq);
                checkOutput("lt", lt, mon1_e.lt);
                checkOutput("words_used", words_used, mon1_e.words);
                checkOutput("done_cycle", cyc, mon1_e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done2: got done=1, expected no pending compare (cycle %0d)", cyc);
            end else begin
                mon2_e = q2.pop_front();
                checkOutput("gt2", gt2, mon2_e.gt);
                checkOutput("eq2", eq2, mon2_e.eq);
                checkOutput("lt2", lt2, mon2_e.lt);
                checkOutput("words_used2", words_used2, mon2_e.words);
                checkOutput("done_cycle2", cyc, mon2_e.due);
            end
        end
    end

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int j;
`ifdef EARLY_EXIT_EN
        j = v.early_words;
`else
        j = WORDS;
`endif
        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        q1.push_back('{v.gt, v.eq, v.lt, j, cyc + 1 + j});
        @(negedge clk);
        start = 1'b0;
        a_in  = ~v.a;
        b_in  = ~v.b;
        checkOutput("busy_run", busy, 1'b1);
        waitDrain(2*WORDS + 4);
        @(negedge clk);
        checkOutput("busy_idle", busy, 1'b0);
        checkOutput("hold_gt", gt, v.gt);
        checkOutput("hold_eq", eq, v.eq);
        checkOutput("hold_lt", lt, v.lt);
    endtask

    // start held high while operands change every cycle; acceptances follow the j+1 cadence.
    task automatic runContinuous(input int ncyc);
        int next_acc;
        logic rgt, req, rlt;
        int rw;
        logic [63:0] a, b;
        next_acc = cyc + 1;
        for (int i = 0; i < ncyc; i++) begin
            a = {16'(i*13 + 1), 16'(i*7), 16'(i ^ 5), 16'(i*3)};
            b = (i % 3 == 0) ? a : (a ^ (64'h1 << ((i*17) % 64)));
            a_in  = a;
            b_in  = b;
            start = 1'b1;
            if (cyc + 1 == next_acc) begin
                refCompare(a, b, W, WORDS, rgt, req, rlt, rw);
                q1.push_back('{rgt, req, rlt, rw, next_acc + rw});
                next_acc = next_acc + rw + 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        waitDrain(2*WORDS + 4);
        @(negedge clk);
    endtask

    task automatic runReset();
        logic saw_done;
        @(negedge clk);
        a_in  = 64'hFFFF_0000_FFFF_0000;
        b_in  = 64'h0000_FFFF_0000_FFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_flags", {gt, eq, lt}, 3'b000);
        checkOutput("rst_words", words_used, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (2*WORDS + 2) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        checkOutput("no_done_after_abort", saw_done, 1'b0);
    endtask

    task automatic runRandom2(input int n);
        logic rgt, req, rlt;
        int rw;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            a2 = 16'($urandom);
            case ($urandom % 4)
                0:       b2 = a2;
                1:       b2 = {a2[15:8], 8'($urandom)};
                default: b2 = 16'($urandom);
            endcase
            refCompare(64'(a2), 64'(b2), W2, WORDS2, rgt, req, rlt, rw);
            q2.push_back('{rgt, req, rlt, rw, cyc + 1 + rw});
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            a2 = ~a2;
            repeat (rw) @(negedge clk);
        end
        waitDrain(2*WORDS2 + 4);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 4};
        vecs[1] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b0, 1'b1, 4};
        vecs[3] = '{64'h0002_0000_0000_FFFF, 64'h0001_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[4] = '{64'h0000_0005_0000_0000, 64'h0000_0006_0000_0000, 1'b0, 1'b0, 1'b1, 2};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 4};
        vecs[6] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4};
        vecs[7] = '{64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[8] = '{64'h0000_0000_0003_FFFF, 64'h0000_0000_0004_0000, 1'b0, 1'b0, 1'b1, 3};

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        a_in   = '0;
        b_in   = '0;
        a2     = '0;
        b2     = '0;
        #12;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_flags", {gt, eq, lt}, 3'b000);
        checkOutput("reset_words", words_used, 0);
        #8;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_flags", {gt, eq, lt}, 3'b000);

        $display("[TB] directed vectors");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] continuous start");
        runContinuous(30);

        $display("[TB] reset during compare");
        runReset();
        applyStimulus(vecs[3]);

        $display("[TB] random pairs on 8x2 instance");
        runRandom2(1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
